// File: rtl/uart_pkg.sv
// uart_pkg: shared UART states, framing constants and baud divisor helper
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS = 8;
    function automatic int calc_div(input longint clk_hz, input longint baud);
        return int'(clk_hz / (baud * OVERSAMPLE));
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample tick generator, one tick every DIV clocks, held at zero by clear
module uart_baud_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = !clear && cnt == W'(DIV - 1);
    always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampling 8N1 UART receiver, MSB first, with framing error and busy status
module uart_receiver
    import uart_pkg::*;
#(
    parameter int UART_INPUT_CLK = 100_000_000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] data
);
    localparam int DIV = calc_div(UART_INPUT_CLK, baud_rate);
    state_t state, state_n;
    logic rx_q, rx_s, tick, mid, last, done_n, err_n;
    logic [3:0] scnt, scnt_n;
    logic [2:0] bcnt, bcnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    uart_baud_gen #(.DIV(DIV)) baud (
        .clk(clk),
        .rst(rst),
        .clear(state == IDLE),
        .tick(tick)
    );
    assign busy = state != IDLE;
    assign mid = tick && scnt == 4'(OVERSAMPLE / 2 - 1);
    assign last = tick && scnt == 4'(OVERSAMPLE - 1);
    always_comb begin
        state_n = state;
        scnt_n = scnt + 4'(tick);
        bcnt_n = bcnt;
        shreg_n = shreg;
        data_n = data;
        done_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: begin
                scnt_n = '0;
                bcnt_n = '0;
                state_n = !rx_s && rx_en ? START : IDLE;
            end
            START: begin
                if (mid) begin
                    scnt_n = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (last) begin
                    shreg_n = {shreg[DATA_BITS-2:0], rx_s};
                    bcnt_n = bcnt + 1'b1;
                    state_n = bcnt == 3'(DATA_BITS - 1) ? STOP : DATA;
                end
            end
            STOP: begin
                if (last) begin
                    state_n = IDLE;
                    done_n = rx_s;
                    err_n = !rx_s;
                    data_n = rx_s ? shreg : data;
                end
            end
            default: state_n = IDLE;
        endcase
        // losing the enable mid-frame drops the frame silently
        if (state != IDLE && !rx_en) begin
            state_n = IDLE;
            done_n = 1'b0;
            err_n = 1'b0;
            data_n = data;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rx_q <= 1'b1;
            rx_s <= 1'b1;
            scnt <= '0;
            bcnt <= '0;
            shreg <= '0;
            data <= '0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            rx_q <= rx;
            rx_s <= rx_q;
            scnt <= scnt_n;
            bcnt <= bcnt_n;
            shreg <= shreg_n;
            data <= data_n;
            done <= done_n;
            err <= err_n;
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames at DIV=4 (64 clocks per bit) with immediate-assertion checks
module tb_uart_receiver;
    localparam int BIT = 64;
    logic clk = 1'b0, rst = 1'b1, rx_en = 1'b1, rx = 1'b1;
    logic busy, done, err;
    logic [7:0] data;
    int compared = 0, mismatched = 0;
    int cyc = 0, t0 = 0, lat = 0, n_done = 0, n_err = 0, busy_drop = 0, nd0 = 0, ne0 = 0;
    logic in_frame = 1'b0, busy_seen = 1'b0;
    logic [7:0] cap[$];

    always #5 clk = ~clk;

    uart_receiver #(.UART_INPUT_CLK(100_000_000), .baud_rate(1_562_500)) dut (
        .clk(clk),
        .rst(rst),
        .rx_en(rx_en),
        .rx(rx),
        .busy(busy),
        .done(done),
        .err(err),
        .data(data)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            lat = cyc - t0;
            cap.push_back(data);
        end
        if (err) n_err++;
        if (in_frame && !busy) busy_drop++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic chk_lat);
        @(negedge clk);
        rx = 1'b0;
        t0 = cyc;
        repeat (2) @(negedge clk);
        if (chk_lat) check("busy_before_3cyc", 32'(busy), 0);
        @(negedge clk);
        if (chk_lat) check("busy_at_3cyc", 32'(busy), 1);
        repeat (2) @(negedge clk);
        in_frame = 1'b1;
        repeat (BIT - 5) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        in_frame = 1'b0;
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_data", 32'(data), 0);
        repeat (20) @(negedge clk);

        send(8'hD6, 1'b1, 1'b1);
        repeat (50) @(negedge clk);
        check("single_done_cnt", n_done, 1);
        check("single_err_cnt", n_err, 0);
        check("single_data", 32'(data), 32'hD6);
        check("single_busy_held", busy_drop, 0);
        check("single_busy_idle", 32'(busy), 0);
        check("single_latency", 32'(lat >= 607 && lat <= 615), 1);

        nd0 = n_done;
        send(8'hD6, 1'b1, 1'b0);
        send(8'hD4, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        check("b2b_done_cnt", n_done, nd0 + 2);
        check("b2b_first", 32'(cap[cap.size() - 2]), 32'hD6);
        check("b2b_second", 32'(cap[cap.size() - 1]), 32'hD4);
        check("b2b_err_cnt", n_err, 0);
        check("b2b_busy_held", busy_drop, 0);

        nd0 = n_done;
        send(8'h55, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("ferr_err_cnt", n_err, 1);
        check("ferr_done_cnt", n_done, nd0);
        check("ferr_data_kept", 32'(data), 32'hD4);
        send(8'h3C, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        check("ferr_next_done", n_done, nd0 + 1);
        check("ferr_next_data", 32'(data), 32'h3C);
        check("ferr_next_err", n_err, 1);

        nd0 = n_done;
        ne0 = n_err;
        busy_seen = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_busy_seen", 32'(busy_seen), 1);
        check("glitch_busy_idle", 32'(busy), 0);
        check("glitch_done", n_done, nd0);
        check("glitch_err", n_err, ne0);

        rx_en = 1'b0;
        busy_seen = 1'b0;
        send(8'h5A, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        check("dis_busy", 32'(busy_seen), 0);
        check("dis_done", n_done, nd0);
        check("dis_err", n_err, ne0);
        check("dis_data", 32'(data), 32'h3C);
        rx_en = 1'b1;
        repeat (20) @(negedge clk);

        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        check("mid_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_data", 32'(data), 0);
        repeat (700) @(negedge clk);
        check("mid_rst_no_done", n_done, nd0);
        check("mid_rst_no_err", n_err, ne0);
        send(8'hA3, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        check("after_rst_done", n_done, nd0 + 1);
        check("after_rst_data", 32'(data), 32'hA3);
        check("after_rst_err", n_err, ne0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
